// File: rtl/watch_fmt_pkg.sv
// Shared definitions for the watch time ASCII frame formatter:
// FSM state encoding, ASCII byte constants and frame lengths.
package watch_fmt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  localparam logic [3:0] FRAME_LEN_NOCRLF = 4'd11;
  localparam logic [3:0] FRAME_LEN_CRLF   = 4'd13;

endpackage

// File: rtl/bin2bcd_2dig.sv
// Combinational 7-bit binary to two decimal digits; values above 99
// saturate to 9/9 so a malformed field still renders as two digits.
module bin2bcd_2dig (
  input  logic [6:0] i_bin,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones
);

  always_comb begin
    o_tens = 4'd9;
    o_ones = 4'd9;
    if (i_bin <= 7'd99) begin
      o_tens = 4'(i_bin / 7'd10);
      o_ones = 4'(i_bin % 7'd10);
    end
  end

endmodule

// File: rtl/watch_time_tx_fmt.sv
// Snapshots the watch time on request and streams "HH:MM:SS.CC"
// (optionally followed by CR LF) into a UART TX FIFO, stalling on full.
module watch_time_tx_fmt
  import watch_fmt_pkg::*;
#(
  parameter bit SEND_CRLF = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req,
  input  logic [6:0] msec,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hour,
  input  logic       i_fifo_full,
  output logic       o_push,
  output logic [7:0] o_data,
  output logic       o_busy
);

  localparam logic [3:0] LAST_IDX = SEND_CRLF ? (FRAME_LEN_CRLF - 4'd1)
                                              : (FRAME_LEN_NOCRLF - 4'd1);

  state_t     r_state;
  logic [6:0] r_msec;
  logic [5:0] r_sec;
  logic [5:0] r_min;
  logic [4:0] r_hour;
  logic [3:0] r_idx;
  logic [7:0] r_dig [0:7];

  logic [6:0] w_bin [0:3];
  logic [7:0] w_dig [0:7];
  logic [7:0] w_byte;
  logic       w_send;
  logic       w_push;

  // Field order here fixes digit pair order in the frame: H, M, S, C.
  assign w_bin[0] = {2'b00, r_hour};
  assign w_bin[1] = {1'b0, r_min};
  assign w_bin[2] = {1'b0, r_sec};
  assign w_bin[3] = r_msec;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_conv
      logic [3:0] w_tens;
      logic [3:0] w_ones;

      bin2bcd_2dig u_bin2bcd (
        .i_bin  (w_bin[gi]),
        .o_tens (w_tens),
        .o_ones (w_ones)
      );

      assign w_dig[2*gi]   = ASCII_0 | {4'b0000, w_tens};
      assign w_dig[2*gi+1] = ASCII_0 | {4'b0000, w_ones};
    end
  endgenerate

  always_comb begin
    w_byte = 8'h00;
    case (r_idx)
      4'd0:    w_byte = r_dig[0];
      4'd1:    w_byte = r_dig[1];
      4'd2:    w_byte = ASCII_COLON;
      4'd3:    w_byte = r_dig[2];
      4'd4:    w_byte = r_dig[3];
      4'd5:    w_byte = ASCII_COLON;
      4'd6:    w_byte = r_dig[4];
      4'd7:    w_byte = r_dig[5];
      4'd8:    w_byte = ASCII_DOT;
      4'd9:    w_byte = r_dig[6];
      4'd10:   w_byte = r_dig[7];
      4'd11:   w_byte = ASCII_CR;
      4'd12:   w_byte = ASCII_LF;
      default: w_byte = 8'h00;
    endcase
  end

  assign w_send = (r_state == SEND);
  assign w_push = w_send && !i_fifo_full;

  assign o_push = w_push;
  assign o_data = w_send ? w_byte : 8'h00;
  assign o_busy = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_idx   <= 4'd0;
      r_msec  <= 7'd0;
      r_sec   <= 6'd0;
      r_min   <= 6'd0;
      r_hour  <= 5'd0;
      for (int i = 0; i < 8; i++) r_dig[i] <= 8'h00;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_req) begin
            r_msec  <= msec;
            r_sec   <= sec;
            r_min   <= min;
            r_hour  <= hour;
            r_state <= CONV;
          end
        end
        CONV: begin
          r_dig   <= w_dig;
          r_idx   <= 4'd0;
          r_state <= SEND;
        end
        SEND: begin
          if (w_push) begin
            r_idx <= r_idx + 4'd1;
            if (r_idx == LAST_IDX) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_watch_time_tx_fmt.sv
// Directed and randomized frames for both CRLF settings, each byte and
// cycle checked against a frame model built from the time values.
module tb_watch_time_tx_fmt;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, req_b;
  logic       full;
  logic [6:0] msec;
  logic [5:0] sec, min;
  logic [4:0] hour;
  logic       push_a, push_b, busy_a, busy_b;
  logic [7:0] data_a, data_b;

  int n_checks = 0;
  int n_fails  = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  watch_time_tx_fmt #(.SEND_CRLF(1'b1)) u_dut_crlf (
    .clk(clk), .rst(rst), .i_req(req_a), .msec(msec), .sec(sec), .min(min),
    .hour(hour), .i_fifo_full(full), .o_push(push_a), .o_data(data_a),
    .o_busy(busy_a)
  );

  watch_time_tx_fmt #(.SEND_CRLF(1'b0)) u_dut_nocrlf (
    .clk(clk), .rst(rst), .i_req(req_b), .msec(msec), .sec(sec), .min(min),
    .hour(hour), .i_fifo_full(full), .o_push(push_b), .o_data(data_b),
    .o_busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void add_pair(input int v);
    int s;
    s = (v > 99) ? 99 : v;
    exp_q.push_back(8'(48 + s / 10));
    exp_q.push_back(8'(48 + s % 10));
  endfunction

  function automatic void build_frame(input int h, input int m, input int s,
                                      input int c, input bit crlf);
    exp_q.delete();
    add_pair(h); exp_q.push_back(8'h3A);
    add_pair(m); exp_q.push_back(8'h3A);
    add_pair(s); exp_q.push_back(8'h2E);
    add_pair(c);
    if (crlf) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endfunction

  // Starts just after a negedge; returns just after the negedge of the
  // first cycle where the DUT is expected back in IDLE.
  task automatic run_frame(input bit sel, input int h, input int m, input int s,
                           input int c, input int st_s, input int st_e,
                           input bit rand_full, input bit zero_c1,
                           input int req_mid, input bit req_last,
                           input int abort_idx);
    int  idx, cyc, len;
    bit  done, aborted, exp_push;
    logic       o_p, o_b;
    logic [7:0] o_d;
    build_frame(h, m, s, c, sel);
    len = exp_q.size();
    hour = 5'(h); min = 6'(m); sec = 6'(s); msec = 7'(c);
    full = 1'b0;
    if (sel) req_a = 1'b1; else req_b = 1'b1;
    idx = 0; cyc = 0; done = 0; aborted = 0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      req_a = 1'b0; req_b = 1'b0;
      if (cyc == 1 && zero_c1) begin
        hour = '0; min = '0; sec = '0; msec = '0;
      end
      full = rand_full ? ($urandom_range(0, 2) == 0) : (cyc >= st_s && cyc < st_e);
      #1;
      o_p = sel ? push_a : push_b;
      o_d = sel ? data_a : data_b;
      o_b = sel ? busy_a : busy_b;
      exp_push = (cyc >= 2) && !full;
      chk("busy_in_frame", o_b, 1);
      chk("push", o_p, exp_push);
      chk("data", o_d, (cyc >= 2) ? exp_q[idx] : 8'h00);
      if (exp_push) begin
        $display("tx byte %0d cyc %0d data %02h", idx, cyc, o_d);
        if (idx == req_mid || (req_last && idx == len - 1)) begin
          if (sel) req_a = 1'b1; else req_b = 1'b1;
        end
        if (idx == abort_idx) begin
          rst = 1'b0;
          aborted = 1;
        end
        idx++;
      end
      if (idx == len || aborted) done = 1;
      if (cyc > 300) begin
        n_checks++; n_fails++;
        $error("FAIL timeout: observed %0d bytes expected %0d", idx, len);
        done = 1;
      end
    end
    @(negedge clk);
    req_a = 1'b0; req_b = 1'b0; full = 1'b0;
    #1;
    chk("busy_end", sel ? busy_a : busy_b, 0);
    chk("push_end", sel ? push_a : push_b, 0);
    chk("data_end", sel ? data_a : data_b, 8'h00);
    if (aborted) rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; req_a = 1'b1; req_b = 1'b1; full = 1'b0;
    hour = 5'd3; min = 6'd4; sec = 6'd5; msec = 7'd6;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_push_a", push_a, 0); chk("rst_busy_a", busy_a, 0); chk("rst_data_a", data_a, 8'h00);
    chk("rst_push_b", push_b, 0); chk("rst_busy_b", busy_b, 0); chk("rst_data_b", data_b, 8'h00);
    @(negedge clk);
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    repeat (2) begin
      @(negedge clk); #1;
      chk("req_in_rst_a", busy_a, 0);
      chk("req_in_rst_b", busy_b, 0);
    end

    run_frame(1, 13, 5, 42, 7, 0, 0, 0, 0, -1, 0, -1);
    run_frame(1, 13, 5, 42, 7, 0, 0, 0, 1, -1, 0, -1);
    run_frame(1, 13, 5, 42, 7, 4, 7, 0, 0, -1, 0, -1);
    run_frame(1, 8, 30, 1, 99, 0, 0, 0, 0, 5, 1, -1);
    run_frame(1, 0, 0, 0, 0, 0, 0, 0, 0, -1, 0, -1);
    run_frame(0, 23, 59, 59, 120, 0, 0, 0, 0, -1, 0, -1);
    run_frame(1, 31, 63, 63, 127, 0, 0, 0, 0, -1, 0, 4);
    run_frame(1, 12, 34, 56, 78, 0, 0, 0, 0, -1, 0, -1);
    run_frame(0, 1, 2, 3, 4, 0, 0, 0, 0, 3, 1, -1);

    for (int k = 0; k < 10; k++) begin
      run_frame(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                int'($urandom_range(0, 127)), 0, 0, 1, 0, -1, 0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
